cpu_out_pio: RTL and testbench



---
 rtl/cpu_pio_pkg.sv | 29 ++
 rtl/cpu_pio_strobe_gen.sv | 75 +++++++
 rtl/cpu_out_pio.sv | 113 +++++++++++
 tb/tb_cpu_out_pio.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pio_pkg.sv
// Shared definitions for the CPU PIO blocks: register addresses, CTRL/status bit
// positions and the strobe sequencer state type.
package cpu_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_SET  = 2'd2;
    localparam logic [1:0] ADDR_CLR  = 2'd3;

    // CTRL write bits
    localparam int CTRL_STROBE_EN_BIT = 0;
    localparam int CTRL_OVR_CLR_BIT   = 1;

    // CTRL read (status) bits
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_OVR_BIT  = 1;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE
    } pio_state_e;

    // Down-counter load value for a phase lasting 'cycles' clocks.
    function automatic logic [7:0] cnt_load(input int cycles);
        return 8'(cycles - 1);
    endfunction

endpackage

// File: rtl/cpu_pio_strobe_gen.sv
// Setup-delay then pulse strobe sequencer, started by a single-cycle trigger.
//   state | meaning
//   IDLE  | waiting for trigger, strobe low
//   SETUP | counting setup delay after an output update
//   PULSE | strobe high for the pulse duration
module cpu_pio_strobe_gen
    import cpu_pio_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic trigger,
    output logic busy,
    output logic strobe
);

    localparam logic [7:0] SETUP_LOAD = cnt_load(SETUP_CYCLES);
    localparam logic [7:0] PULSE_LOAD = cnt_load(PULSE_CYCLES);

    pio_state_e state_q;
    logic [7:0] cnt_q;
    logic       strobe_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        // A zero setup delay raises the strobe together with the data.
                        if (SETUP_CYCLES == 0) begin
                            state_q  <= PULSE;
                            cnt_q    <= PULSE_LOAD;
                            strobe_q <= 1'b1;
                        end else begin
                            state_q <= SETUP;
                            cnt_q   <= SETUP_LOAD;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_q == 8'd0) begin
                        state_q  <= PULSE;
                        cnt_q    <= PULSE_LOAD;
                        strobe_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                PULSE: begin
                    if (cnt_q == 8'd0) begin
                        state_q  <= IDLE;
                        strobe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    cnt_q    <= '0;
                    strobe_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign strobe = strobe_q;

endmodule

// File: rtl/cpu_out_pio.sv
// Avalon-MM output PIO: CPU-written data register driving out_port, with a timed
// strobe after each update. Readback of the register map needs CPU_OUT_PIO_READBACK_EN.
module cpu_out_pio
    import cpu_pio_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int               SETUP_CYCLES = 2,
    parameter int               PULSE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             write,
    input  logic             read,
    input  logic [31:0]      writedata,
    output logic             waitrequest,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port,
    output logic             out_strobe
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             strobe_en_q;
    logic             ovr_q;
    logic             busy;
    logic             accept;
    logic             trigger;
    logic [WIDTH-1:0] wdata;

    assign wdata = writedata[WIDTH-1:0];

    // CTRL stays reachable while busy so software can poll and reconfigure.
    assign waitrequest = write && (address != ADDR_CTRL) && busy;
    assign accept      = write && !waitrequest;
    assign trigger     = accept && (address != ADDR_CTRL) && strobe_en_q;

    always_comb begin
        data_d = data_q;
        if (accept) begin
            case (address)
                ADDR_DATA: data_d = wdata;
                ADDR_SET:  data_d = data_q | wdata;
                ADDR_CLR:  data_d = data_q & ~wdata;
                default:   data_d = data_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q      <= RESET_VALUE;
            strobe_en_q <= 1'b1;
            ovr_q       <= 1'b0;
        end else begin
            data_q <= data_d;
            if (accept && (address == ADDR_CTRL)) begin
                strobe_en_q <= writedata[CTRL_STROBE_EN_BIT];
                if (writedata[CTRL_OVR_CLR_BIT]) begin
                    ovr_q <= 1'b0;
                end
            end
            if (write && waitrequest) begin
                ovr_q <= 1'b1;
            end
        end
    end

    cpu_pio_strobe_gen #(
        .SETUP_CYCLES (SETUP_CYCLES),
        .PULSE_CYCLES (PULSE_CYCLES)
    ) u_strobe_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .trigger (trigger),
        .busy    (busy),
        .strobe  (out_strobe)
    );

    assign out_port = data_q;

`ifdef CPU_OUT_PIO_READBACK_EN
    logic [31:0] readdata_q;
    logic [31:0] status;

    always_comb begin
        status                = '0;
        status[STAT_BUSY_BIT] = busy;
        status[STAT_OVR_BIT]  = ovr_q;
    end

    // Sampled from pre-edge state, so a same-cycle write is not visible yet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else if (read) begin
            case (address)
                ADDR_DATA: readdata_q <= 32'(data_q);
                ADDR_CTRL: readdata_q <= status;
                default:   readdata_q <= '0;
            endcase
        end
    end

    assign readdata = readdata_q;
`else
    logic unused_readback;
    assign unused_readback = &{1'b0, read, ovr_q};
    assign readdata        = '0;
`endif

endmodule

// File: tb/tb_cpu_out_pio.sv
// Randomized and directed bench for cpu_out_pio against a timestamp-based reference model.
module tb_cpu_out_pio;

    localparam int S = 2;
    localparam int P = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic [31:0] out_port;
    logic        out_strobe;

    logic [1:0]  b_address;
    logic        b_write;
    logic        b_read;
    logic [31:0] b_writedata;
    logic        b_waitrequest;
    logic [31:0] b_readdata;
    logic [31:0] b_out_port;
    logic        b_out_strobe;

    always #5 clk = ~clk;

    cpu_out_pio #(.WIDTH(32), .RESET_VALUE(32'h0), .SETUP_CYCLES(S), .PULSE_CYCLES(P)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .write(write), .read(read),
        .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata),
        .out_port(out_port), .out_strobe(out_strobe)
    );

    cpu_out_pio #(.WIDTH(32), .RESET_VALUE(32'h0), .SETUP_CYCLES(0), .PULSE_CYCLES(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .address(b_address), .write(b_write), .read(b_read),
        .writedata(b_writedata), .waitrequest(b_waitrequest), .readdata(b_readdata),
        .out_port(b_out_port), .out_strobe(b_out_strobe)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a sequence started by a write accepted at edge t keeps the
    // block busy through edges t..t+S+P-1 and shows the strobe after edges t+S..t+S+P-1.
    logic [31:0] m_data;
    bit          m_en;
    bit          m_ovr;
    logic [31:0] m_rd;
    int          m_t;
    int          n = 0;
    int          strobes_seen = 0;

    always @(posedge out_strobe) strobes_seen++;

    function automatic bit m_busy();
        return n < m_t + S + P;
    endfunction

    function automatic bit m_strobe();
        return (n >= m_t + S) && (n < m_t + S + P);
    endfunction

    task automatic model_reset();
        m_data = 32'h0;
        m_en   = 1'b1;
        m_ovr  = 1'b0;
        m_rd   = 32'h0;
        m_t    = -1000;
    endtask

    task automatic cycle(input bit w, input bit r, input logic [1:0] a,
                         input logic [31:0] wd, output bit acc);
        bit busy_now;
        bit trig;
        @(negedge clk);
        check_eq("out_port", out_port, m_data);
        check_eq("out_strobe", 32'(out_strobe), 32'(m_strobe()));
        check_eq("readdata", readdata, m_rd);
        write     = w;
        read      = r;
        address   = a;
        writedata = wd;
        #1;
        busy_now = m_busy();
        acc      = w && !((a != 2'd1) && busy_now);
        check_eq("waitrequest", 32'(waitrequest), 32'(w && (a != 2'd1) && busy_now));
        if (r) begin
`ifdef CPU_OUT_PIO_READBACK_EN
            case (a)
                2'd0:    m_rd = m_data;
                2'd1:    m_rd = {30'd0, m_ovr, busy_now};
                default: m_rd = 32'h0;
            endcase
`else
            m_rd = 32'h0;
`endif
        end
        if (w && !acc) m_ovr = 1'b1;
        trig = acc && (a != 2'd1) && m_en;
        if (acc) begin
            case (a)
                2'd0: m_data = wd;
                2'd1: begin
                    m_en = wd[0];
                    if (wd[1]) m_ovr = 1'b0;
                end
                2'd2: m_data = m_data | wd;
                default: m_data = m_data & ~wd;
            endcase
        end
        if (trig) m_t = n + 1;
        @(posedge clk);
        n++;
    endtask

    task automatic idle(input int cycles);
        bit acc;
        for (int i = 0; i < cycles; i++) cycle(1'b0, 1'b0, 2'd0, 32'h0, acc);
    endtask

    task automatic wr_wait(input logic [1:0] a, input logic [31:0] wd);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, a, wd, acc);
            if (acc) break;
        end
        check_eq("wr_accept", 32'(acc), 32'h1);
    endtask

    function automatic logic [31:0] rb(input logic [31:0] v);
`ifdef CPU_OUT_PIO_READBACK_EN
        return v;
`else
        return 32'h0 & v;
`endif
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int s0;
        logic [1:0] ra;
        logic [31:0] rwd;

        reset_n = 1'b0;
        write = 1'b0; read = 1'b0; address = 2'd0; writedata = 32'h0;
        b_write = 1'b0; b_read = 1'b0; b_address = 2'd0; b_writedata = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        check_eq("rst_out_port", out_port, 32'h0);
        check_eq("rst_strobe", 32'(out_strobe), 32'h0);
        check_eq("rst_readdata", readdata, 32'h0);

        // Single DATA write with busy polled through CTRL.
        cycle(1'b1, 1'b0, 2'd0, 32'hA5A50001, acc);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 2'd1, 32'h0, acc);
        check_eq("t1_out_port", out_port, 32'hA5A50001);

        // Back-to-back DATA/SET/CLR stalled by waitrequest.
        s0 = strobes_seen;
        wr_wait(2'd0, 32'h0000FF00);
        wr_wait(2'd2, 32'h0000000F);
        wr_wait(2'd3, 32'h00000F00);
        idle(7);
        check_eq("t2_out_port", out_port, 32'h0000F00F);
        check_eq("t2_strobes", 32'(strobes_seen - s0), 32'd3);
        cycle(1'b1, 1'b0, 2'd1, 32'h3, acc);

        // Strobe disabled: data still updates, no strobe, no stall.
        cycle(1'b1, 1'b0, 2'd1, 32'h0, acc);
        s0 = strobes_seen;
        cycle(1'b1, 1'b0, 2'd0, 32'h12345678, acc);
        cycle(1'b1, 1'b0, 2'd2, 32'h80000000, acc);
        idle(6);
        check_eq("t3_out_port", out_port, 32'h92345678);
        check_eq("t3_strobes", 32'(strobes_seen - s0), 32'd0);
        cycle(1'b1, 1'b0, 2'd1, 32'h3, acc);
        idle(2);

        // Abandoned write while busy sets ovr; clearing it leaves busy visible.
        cycle(1'b1, 1'b0, 2'd0, 32'h00000055, acc);
        cycle(1'b1, 1'b0, 2'd2, 32'h000000F0, acc);
        cycle(1'b0, 1'b1, 2'd1, 32'h0, acc);
        #1 check_eq("t6_ctrl_ovr", readdata, rb(32'h3));
        cycle(1'b1, 1'b0, 2'd1, 32'h3, acc);
        cycle(1'b0, 1'b1, 2'd1, 32'h0, acc);
        #1 check_eq("t6_ctrl_busy", readdata, rb(32'h1));
        idle(3);
        cycle(1'b0, 1'b1, 2'd1, 32'h0, acc);
        #1 check_eq("t6_ctrl_idle", readdata, rb(32'h0));
        cycle(1'b0, 1'b1, 2'd0, 32'h0, acc);
        #1 check_eq("t6_data_rd", readdata, rb(32'h00000055));
        idle(2);

        // Reset during PULSE, with strobe_en cleared mid-sequence beforehand.
        cycle(1'b1, 1'b0, 2'd0, 32'h0BADF00D, acc);
        cycle(1'b1, 1'b0, 2'd1, 32'h0, acc);
        idle(2);
        #2 check_eq("t4_pre_strobe", 32'(out_strobe), 32'h1);
        reset_n = 1'b0;
        #1;
        check_eq("t4_rst_strobe", 32'(out_strobe), 32'h0);
        check_eq("t4_rst_out_port", out_port, 32'h0);
        write = 1'b0; read = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cycle(1'b0, 1'b1, 2'd1, 32'h0, acc);
        s0 = strobes_seen;
        cycle(1'b1, 1'b0, 2'd0, 32'h00000077, acc);
        idle(6);
        check_eq("t4_strobe_en", 32'(strobes_seen - s0), 32'd1);

        // SETUP_CYCLES=0, PULSE_CYCLES=1 instance.
        @(negedge clk);
        check_eq("t5_pre_strobe", 32'(b_out_strobe), 32'h0);
        b_write = 1'b1; b_address = 2'd0; b_writedata = 32'hCAFE0001;
        #1 check_eq("t5_wait_idle", 32'(b_waitrequest), 32'h0);
        @(posedge clk);
        #1;
        check_eq("t5_out_port", b_out_port, 32'hCAFE0001);
        check_eq("t5_strobe_hi", 32'(b_out_strobe), 32'h1);
        check_eq("t5_wait_busy", 32'(b_waitrequest), 32'h1);
        @(negedge clk);
        b_write = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t5_strobe_lo", 32'(b_out_strobe), 32'h0);

        // Randomized traffic, including abandoned writes and CTRL updates.
        for (int i = 0; i < 500; i++) begin
            ra  = 2'($urandom_range(0, 3));
            rwd = $urandom;
            if (ra == 2'd1) rwd[0] = ($urandom_range(0, 3) != 0);
            cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), ra, rwd, acc);
        end
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
